// File: rtl/hcu_arbiter_if.sv
// Bus bundle for the hash-core arbiter: requester ports, hash-core word and
// digest streams, digest consumer stream and status.
interface hcu_arbiter_if #(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_DIGEST_WIDTH       = 512,
  parameter int unsigned PORT_ID_WIDTH        = 2
);
  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
  logic [NUM_PORTS-1:0]                      s_axis_tvalid;
  logic [NUM_PORTS-1:0]                      s_axis_tlast;
  logic [NUM_PORTS-1:0]                      s_axis_tready;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  c_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] c_axis_tuser;
  logic                            c_axis_tvalid;
  logic                            c_axis_tlast;
  logic                            c_axis_tready;

  logic [C_DIGEST_WIDTH-1:0]       h_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] h_axis_tuser;
  logic                            h_axis_tvalid;
  logic                            h_axis_tlast;
  logic                            h_axis_tready;

  logic [C_DIGEST_WIDTH-1:0]       m_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic [PORT_ID_WIDTH-1:0]        m_axis_tdest;
  logic                            m_axis_tready;

  logic                            busy;
  logic [31:0]                     pkt_count;

  // Arbiter side
  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output c_axis_tdata, c_axis_tuser, c_axis_tvalid, c_axis_tlast,
    input  c_axis_tready,
    input  h_axis_tdata, h_axis_tuser, h_axis_tvalid, h_axis_tlast,
    output h_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
    input  m_axis_tready,
    output busy, pkt_count
  );

  // Environment side: requesters, hash core and digest consumer
  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  c_axis_tdata, c_axis_tuser, c_axis_tvalid, c_axis_tlast,
    output c_axis_tready,
    output h_axis_tdata, h_axis_tuser, h_axis_tvalid, h_axis_tlast,
    input  h_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tvalid, m_axis_tlast, m_axis_tdest,
    output m_axis_tready,
    input  busy, pkt_count
  );
endinterface

// File: rtl/hcu_arbiter.sv
// Round-robin arbiter sharing one hash core among NUM_PORTS stream requesters;
// a port owns the core from grant until its digest has been delivered.
module hcu_arbiter #(
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 64,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_DIGEST_WIDTH       = 512,
  parameter int unsigned PORT_ID_WIDTH        = 2
) (
  input  logic         axis_aclk,
  input  logic         axis_reset,
  hcu_arbiter_if.slave bus
);
  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned UW = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned HW = C_DIGEST_WIDTH;
  localparam int unsigned PW = PORT_ID_WIDTH;
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DIGEST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [PW-1:0] last_grant_q, last_grant_d;
  logic [31:0]   pkt_count_q, pkt_count_d;

  logic [DW-1:0] port_data [NUM_PORTS];
  logic [UW-1:0] port_user [NUM_PORTS];

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign port_data[k] = bus.s_axis_tdata[k*DW +: DW];
    assign port_user[k] = bus.s_axis_tuser[k*UW +: UW];
  end

  // Round-robin search starting one past the previous owner
  logic          rr_found;
  logic [PW-1:0] rr_winner;
  logic [PW-1:0] rr_cand;

  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_grant_q;
    rr_cand   = last_grant_q;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      rr_cand = (rr_cand == LAST_PORT) ? '0 : rr_cand + PW'(1);
      if (!rr_found && bus.s_axis_tvalid[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  logic [NUM_PORTS-1:0] s_tready_c;
  logic [DW-1:0]        c_tdata_c;
  logic [UW-1:0]        c_tuser_c;
  logic                 c_tvalid_c;
  logic                 c_tlast_c;
  logic                 h_tready_c;
  logic [HW-1:0]        m_tdata_c;
  logic [UW-1:0]        m_tuser_c;
  logic                 m_tvalid_c;
  logic                 m_tlast_c;
  logic [PW-1:0]        m_tdest_c;

  // Next-state and datapath steering
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pkt_count_d  = pkt_count_q;
    s_tready_c   = '0;
    c_tdata_c    = '0;
    c_tuser_c    = '0;
    c_tvalid_c   = 1'b0;
    c_tlast_c    = 1'b0;
    h_tready_c   = 1'b0;
    m_tdata_c    = '0;
    m_tuser_c    = '0;
    m_tvalid_c   = 1'b0;
    m_tlast_c    = 1'b0;
    m_tdest_c    = '0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d = rr_winner;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Owner keeps the core through stalls until its tlast is accepted
        c_tdata_c           = port_data[grant_q];
        c_tuser_c           = port_user[grant_q];
        c_tvalid_c          = bus.s_axis_tvalid[grant_q];
        c_tlast_c           = bus.s_axis_tlast[grant_q];
        s_tready_c[grant_q] = bus.c_axis_tready;
        if (c_tvalid_c && bus.c_axis_tready && c_tlast_c) begin
          state_d = DIGEST;
        end
      end
      DIGEST: begin
        m_tdata_c  = bus.h_axis_tdata;
        m_tuser_c  = bus.h_axis_tuser;
        m_tvalid_c = bus.h_axis_tvalid;
        m_tlast_c  = bus.h_axis_tlast;
        m_tdest_c  = grant_q;
        h_tready_c = bus.m_axis_tready;
        if (bus.h_axis_tvalid && bus.m_axis_tready) begin
          last_grant_d = grant_q;
          pkt_count_d  = pkt_count_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_PORT;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign bus.s_axis_tready = s_tready_c;
  assign bus.c_axis_tdata  = c_tdata_c;
  assign bus.c_axis_tuser  = c_tuser_c;
  assign bus.c_axis_tvalid = c_tvalid_c;
  assign bus.c_axis_tlast  = c_tlast_c;
  assign bus.h_axis_tready = h_tready_c;
  assign bus.m_axis_tdata  = m_tdata_c;
  assign bus.m_axis_tuser  = m_tuser_c;
  assign bus.m_axis_tvalid = m_tvalid_c;
  assign bus.m_axis_tlast  = m_tlast_c;
  assign bus.m_axis_tdest  = m_tdest_c;
  assign bus.busy          = (state_q != IDLE);
  assign bus.pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_hcu_arbiter.sv
// Bench for hcu_arbiter: packet sources, a hash-core model and a digest
// scoreboard checked against the expected service order.
module tb_hcu_arbiter;
  localparam int unsigned NP = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned UW = 128;
  localparam int unsigned HW = 512;
  localparam int unsigned PW = 2;

  logic axis_aclk  = 1'b0;
  logic axis_reset = 1'b1;

  hcu_arbiter_if #(.NUM_PORTS(NP), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
                   .C_DIGEST_WIDTH(HW), .PORT_ID_WIDTH(PW)) bus ();

  hcu_arbiter #(.NUM_PORTS(NP), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
                .C_DIGEST_WIDTH(HW), .PORT_ID_WIDTH(PW)) dut (
    .axis_aclk (axis_aclk),
    .axis_reset(axis_reset),
    .bus       (bus)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    int            port;
    logic [HW-1:0] data;
    logic [UW-1:0] user;
  } sb_t;

  sb_t sb[$];
  int  exp_order[$];
  int  checks = 0;
  int  errors = 0;

  int unsigned   pkts_left [NP];
  int unsigned   beat      [NP];
  int unsigned   len       [NP];
  int unsigned   serial    [NP];
  logic [DW-1:0] exp_acc   [NP];
  bit            gap       [NP];

  bit            c_ready_en, m_ready_en, h_pend;
  logic [DW-1:0] h_acc;
  logic [UW-1:0] h_user;
  int            cyc, last_m_cyc, tat_min, tat_max, c_beats, busy_cycles;
  bit            have_m;

  logic [NP-1:0] samp_s_tready;
  logic          samp_c_tvalid, samp_busy, samp_m_tvalid, samp_m_tlast, samp_h_tready;
  logic [31:0]   samp_pkt_count;

  function automatic logic [DW-1:0] src_word(input int p, input int unsigned s, input int unsigned b);
    return {8'hA5, 8'(p), 16'(s), 32'(b)};
  endfunction

  function automatic logic [UW-1:0] src_user(input int p, input int unsigned s);
    return {24'hC0DEC0, 8'(p), 32'(s), 64'h0123_4567_89AB_CDEF};
  endfunction

  // Order-sensitive digest stand-in used by both the sources and the core model
  function automatic logic [DW-1:0] mix(input logic [DW-1:0] acc, input logic [DW-1:0] w);
    return {acc[DW-2:0], acc[DW-1]} ^ w;
  endfunction

  task automatic load(input int p, input int unsigned npkts, input int unsigned l);
    pkts_left[p] = npkts;
    len[p]       = l;
  endtask

  // One clock: drive at negedge, sample 1ns later, account handshakes for the next posedge
  task automatic step();
    int tat;
    @(negedge axis_aclk);
    for (int p = 0; p < NP; p++) begin
      bus.s_axis_tvalid[p]          = (pkts_left[p] != 0) && !gap[p];
      bus.s_axis_tlast[p]           = (beat[p] == len[p] - 1);
      bus.s_axis_tdata[p*DW +: DW]  = src_word(p, serial[p], beat[p]);
      bus.s_axis_tuser[p*UW +: UW]  = src_user(p, serial[p]);
    end
    bus.c_axis_tready = c_ready_en;
    bus.h_axis_tvalid = h_pend;
    bus.h_axis_tdata  = {8{h_acc}};
    bus.h_axis_tuser  = h_user;
    bus.h_axis_tlast  = h_pend;
    bus.m_axis_tready = m_ready_en;
    #1;
    cyc++;
    samp_s_tready  = bus.s_axis_tready;
    samp_c_tvalid  = bus.c_axis_tvalid;
    samp_busy      = bus.busy;
    samp_m_tvalid  = bus.m_axis_tvalid;
    samp_m_tlast   = bus.m_axis_tlast;
    samp_h_tready  = bus.h_axis_tready;
    samp_pkt_count = bus.pkt_count;
    if (samp_busy) busy_cycles++;

    for (int p = 0; p < NP; p++) begin
      if (bus.s_axis_tvalid[p] && bus.s_axis_tready[p]) begin
        checks++;
        if (exp_order.size() == 0 || exp_order[0] != p) begin
          errors++;
          $display("FAIL owner: beat taken from port %0d, expected owner %0d", p,
                   (exp_order.size() != 0) ? exp_order[0] : -1);
        end
        if (beat[p] == 0 && have_m) begin
          tat = cyc - last_m_cyc;
          if (tat < tat_min) tat_min = tat;
          if (tat > tat_max) tat_max = tat;
        end
        exp_acc[p] = mix(exp_acc[p], src_word(p, serial[p], beat[p]));
        if (beat[p] == len[p] - 1) begin
          sb.push_back('{p, {8{exp_acc[p]}}, src_user(p, serial[p])});
          exp_acc[p] = '0;
          beat[p]    = 0;
          serial[p]++;
          pkts_left[p]--;
        end else begin
          beat[p]++;
        end
      end
    end

    if (bus.h_axis_tvalid && bus.h_axis_tready) begin
      h_pend = 1'b0;
      h_acc  = '0;
    end

    if (bus.c_axis_tvalid && bus.c_axis_tready) begin
      c_beats++;
      h_acc = mix(h_acc, bus.c_axis_tdata);
      if (bus.c_axis_tlast) begin
        h_pend = 1'b1;
        h_user = bus.c_axis_tuser;
      end
    end

    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      sb_t e;
      last_m_cyc = cyc;
      have_m     = 1'b1;
      checks++;
      if (exp_order.size() == 0 || int'(bus.m_axis_tdest) != exp_order[0]) begin
        errors++;
        $display("FAIL order: tdest %0d, expected %0d", bus.m_axis_tdest,
                 (exp_order.size() != 0) ? exp_order[0] : -1);
      end
      if (exp_order.size() != 0) void'(exp_order.pop_front());
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL digest_sb: digest delivered with empty scoreboard, want none");
      end else begin
        e = sb.pop_front();
        checks += 3;
        if (int'(bus.m_axis_tdest) != e.port) begin
          errors++;
          $display("FAIL tdest: got %0d want %0d", bus.m_axis_tdest, e.port);
        end
        if (bus.m_axis_tdata !== e.data) begin
          errors++;
          $display("FAIL tdata: got %0h want %0h", bus.m_axis_tdata, e.data);
        end
        if (bus.m_axis_tuser !== e.user || bus.m_axis_tlast !== 1'b1) begin
          errors++;
          $display("FAIL tuser_tlast: got %0h/%0b want %0h/1", bus.m_axis_tuser, bus.m_axis_tlast, e.user);
        end
      end
    end
  endtask

  task automatic run_to_idle(input int budget, input string name);
    int n = 0;
    while (exp_order.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_order.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d packets outstanding, want 0", name, exp_order.size());
    end
  endtask

  task automatic do_reset();
    axis_reset = 1'b1;
    for (int p = 0; p < NP; p++) begin
      pkts_left[p] = 0; beat[p] = 0; len[p] = 0; serial[p] = 0;
      exp_acc[p] = '0; gap[p] = 1'b0;
    end
    sb.delete();
    exp_order.delete();
    c_ready_en = 1'b1; m_ready_en = 1'b1; h_pend = 1'b0;
    h_acc = '0; h_user = '0; have_m = 1'b0;
    c_beats = 0; busy_cycles = 0; tat_min = 1000; tat_max = 0;
    bus.s_axis_tvalid = '0; bus.s_axis_tlast = '0;
    bus.s_axis_tdata  = '0; bus.s_axis_tuser = '0;
    bus.c_axis_tready = 1'b0;
    bus.h_axis_tvalid = 1'b0; bus.h_axis_tlast = 1'b0;
    bus.h_axis_tdata  = '0; bus.h_axis_tuser = '0;
    bus.m_axis_tready = 1'b0;
    repeat (2) @(negedge axis_aclk);
    axis_reset = 1'b0;
  endtask

  task automatic test_reset();
    axis_reset = 1'b1;
    bus.s_axis_tvalid = '1; bus.s_axis_tlast = '1;
    bus.s_axis_tdata  = '0; bus.s_axis_tuser = '0;
    bus.c_axis_tready = 1'b1;
    bus.h_axis_tvalid = 1'b1; bus.h_axis_tlast = 1'b1;
    bus.h_axis_tdata  = '1; bus.h_axis_tuser = '0;
    bus.m_axis_tready = 1'b1;
    repeat (2) @(negedge axis_aclk);
    #1;
    checks += 4;
    if (bus.s_axis_tready !== '0) begin errors++; $display("FAIL rst_s_tready: got %0b want 0", bus.s_axis_tready); end
    if (bus.c_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_c_tvalid: got %0b want 0", bus.c_axis_tvalid); end
    if (bus.h_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_h_tready: got %0b want 0", bus.h_axis_tready); end
    if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %0b want 0", bus.m_axis_tvalid); end
    checks += 4;
    if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %0b want 0", bus.m_axis_tlast); end
    if (bus.m_axis_tdest !== '0) begin errors++; $display("FAIL rst_tdest: got %0d want 0", bus.m_axis_tdest); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    if (bus.pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", bus.pkt_count); end
  endtask

  task automatic test_two_ports();
    do_reset();
    load(0, 1, 16);
    load(2, 1, 16);
    exp_order = '{0, 2};
    step();
    checks += 2;
    if (samp_busy !== 1'b0) begin errors++; $display("FAIL arb_cycle_busy: got %0b want 0", samp_busy); end
    if (samp_c_tvalid !== 1'b0) begin errors++; $display("FAIL arb_cycle_c_tvalid: got %0b want 0", samp_c_tvalid); end
    step();
    checks += 2;
    if (samp_busy !== 1'b1) begin errors++; $display("FAIL grant_busy: got %0b want 1", samp_busy); end
    if (samp_c_tvalid !== 1'b1) begin errors++; $display("FAIL grant_c_tvalid: got %0b want 1", samp_c_tvalid); end
    run_to_idle(100, "two_ports");
    step();
    checks++;
    if (samp_pkt_count !== 32'd2) begin errors++; $display("FAIL two_ports_count: got %0d want 2", samp_pkt_count); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int p = 0; p < NP; p++) load(p, 2, 4);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_to_idle(200, "round_robin");
    step();
    checks += 3;
    if (samp_pkt_count !== 32'd8) begin errors++; $display("FAIL rr_count: got %0d want 8", samp_pkt_count); end
    if (tat_min != 2) begin errors++; $display("FAIL turnaround_min: got %0d want 2", tat_min); end
    if (tat_max != 2) begin errors++; $display("FAIL turnaround_max: got %0d want 2", tat_max); end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    load(1, 1, 8);
    load(3, 1, 4);
    exp_order = '{1, 3};
    while (beat[1] < 3 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (beat[1] < 3) begin errors++; $display("FAIL stall_start_timeout: port1 beat %0d want 3", beat[1]); end
    gap[1] = 1'b1;
    repeat (5) begin
      step();
      checks += 3;
      if (samp_c_tvalid !== 1'b0) begin errors++; $display("FAIL stall_c_tvalid: got %0b want 0", samp_c_tvalid); end
      if (samp_s_tready[3] !== 1'b0) begin errors++; $display("FAIL stall_port3_tready: got %0b want 0", samp_s_tready[3]); end
      if (samp_busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %0b want 1", samp_busy); end
    end
    gap[1] = 1'b0;
    run_to_idle(60, "stall");
  endtask

  task automatic test_digest_backpressure();
    int n = 0;
    do_reset();
    load(0, 1, 2);
    exp_order = '{0};
    m_ready_en = 1'b0;
    do begin
      step();
      n++;
    end while (samp_m_tvalid !== 1'b1 && n < 20);
    checks++;
    if (samp_m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_digest_timeout: m_tvalid %0b want 1", samp_m_tvalid); end
    for (int i = 0; i < 10; i++) begin
      if (i != 0) step();
      checks += 3;
      if (samp_m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_m_tvalid: cycle %0d got %0b want 1", i + 1, samp_m_tvalid); end
      if (samp_h_tready !== 1'b0) begin errors++; $display("FAIL bp_h_tready: cycle %0d got %0b want 0", i + 1, samp_h_tready); end
      if (samp_busy !== 1'b1) begin errors++; $display("FAIL bp_busy: cycle %0d got %0b want 1", i + 1, samp_busy); end
    end
    m_ready_en = 1'b1;
    step();
    step();
    checks += 3;
    if (samp_busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy: got %0b want 0", samp_busy); end
    if (samp_m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_idle_m_tvalid: got %0b want 0", samp_m_tvalid); end
    if (exp_order.size() != 0 || samp_pkt_count !== 32'd1) begin
      errors++;
      $display("FAIL bp_delivered: outstanding %0d count %0d want 0/1", exp_order.size(), samp_pkt_count);
    end
  endtask

  task automatic test_early_digest();
    do_reset();
    h_pend = 1'b1;
    h_acc  = 64'hDEAD_BEEF_0000_0001;
    h_user = '1;
    repeat (3) begin
      step();
      checks += 3;
      if (samp_h_tready !== 1'b0) begin errors++; $display("FAIL early_h_tready: got %0b want 0", samp_h_tready); end
      if (samp_m_tvalid !== 1'b0) begin errors++; $display("FAIL early_m_tvalid: got %0b want 0", samp_m_tvalid); end
      if (samp_m_tlast !== 1'b0) begin errors++; $display("FAIL early_m_tlast: got %0b want 0", samp_m_tlast); end
    end
    checks++;
    if (h_pend !== 1'b1) begin errors++; $display("FAIL early_held: digest consumed %0b want still pending", !h_pend); end
    h_pend = 1'b0;
    h_acc  = '0;
    h_user = '0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    load(0, 1, 2);
    exp_order = '{0};
    run_to_idle(30, "reset_mid_pre");
    load(1, 1, 16);
    exp_order.push_back(1);
    while (beat[1] < 7 && n < 60) begin
      step();
      n++;
    end
    checks += 2;
    if (beat[1] < 7) begin errors++; $display("FAIL reset_mid_timeout: port1 beat %0d want 7", beat[1]); end
    if (samp_c_tvalid !== 1'b1) begin errors++; $display("FAIL reset_mid_streaming: c_tvalid %0b want 1", samp_c_tvalid); end
    axis_reset = 1'b1;
    #1;
    checks += 4;
    if (bus.s_axis_tready !== '0) begin errors++; $display("FAIL abort_s_tready: got %0b want 0", bus.s_axis_tready); end
    if (bus.c_axis_tvalid !== 1'b0) begin errors++; $display("FAIL abort_c_tvalid: got %0b want 0", bus.c_axis_tvalid); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", bus.busy); end
    if (bus.pkt_count !== 32'd0) begin errors++; $display("FAIL abort_pkt_count: got %0d want 0", bus.pkt_count); end
    do_reset();
    load(0, 1, 4);
    load(1, 1, 4);
    exp_order = '{0, 1};
    run_to_idle(60, "reset_mid_post");
  endtask

  task automatic test_single_beat();
    do_reset();
    load(3, 1, 1);
    exp_order = '{3};
    run_to_idle(20, "single_beat");
    step();
    checks += 3;
    if (c_beats != 1) begin errors++; $display("FAIL single_beats: got %0d want 1", c_beats); end
    if (busy_cycles != 2) begin errors++; $display("FAIL single_busy_cycles: got %0d want 2", busy_cycles); end
    if (samp_pkt_count !== 32'd1) begin errors++; $display("FAIL single_count: got %0d want 1", samp_pkt_count); end
  endtask

  initial begin
    cyc = 0;
    last_m_cyc = 0;
    test_reset();
    test_two_ports();
    test_round_robin();
    test_stall();
    test_digest_backpressure();
    test_early_digest();
    test_reset_mid();
    test_single_beat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
